// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Shares one SPI master between two requesters. A round-robin arbiter picks
// one requester, latches its byte into m_wdata, issues a single start pulse
// to the SPI master once it is not busy, waits for the master's m_done,
// captures the received byte into rdata and reports the outcome to the served
// requester with a done (success) or err (timeout) pulse. A watchdog aborts
// the transfer if ISSUE+XFER lasts TIMEOUT cycles without m_done.
//
// Ports
//   clk              system clock, all state changes on its rising edge
//   rst              asynchronous reset, active low
//   req0/req1        requester n wants one transfer (held until done/err)
//   wdata0/wdata1    byte to send for requester n, sampled at grant
//   gnt0/gnt1        requester n owns the SPI master (ISSUE and XFER)
//   done0/done1      one-cycle pulse: transfer completed, rdata valid
//   err0/err1        one-cycle pulse: transfer aborted by timeout
//   rdata            last byte received from the SPI master
//   m_start          one-cycle start pulse to the SPI master
//   m_wdata          byte presented to the SPI master, stable until RELEASE
//   m_busy           SPI master cannot accept a start
//   m_done           one-cycle pulse from the SPI master, m_rdata valid
//   m_rdata          byte received by the SPI master
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              m_start,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_owner;     // requester currently being served
    logic                r_last;      // last-served requester (round-robin pointer)
    logic                r_ok;        // 1 = completed, 0 = aborted
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [DATA_W-1:0]   r_rdata;

    state_t              w_state_nxt;
    logic                w_sel;
    logic                w_start;
    logic                w_capture;
    logic                w_abort;
    logic                w_timeout;
    logic                w_owned;

    // Winner: a lone requester wins; on a tie the one not served last wins.
    assign w_sel     = (req0 && req1) ? ~r_last : req1;
    assign w_timeout = (r_cnt == TMO_LAST);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_RELEASE;
                end else if (!m_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                // m_done takes priority over a timeout in the same cycle.
                if (m_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RELEASE;
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_ok      <= 1'b0;
            r_cnt     <= '0;
            r_m_wdata <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_owner   <= w_sel;
                        r_m_wdata <= w_sel ? wdata1 : wdata0;
                        r_cnt     <= '0;
                    end
                end
                S_ISSUE, S_XFER: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_RELEASE: begin
                    r_last <= r_owner;
                end
                default: ;
            endcase
            if (w_capture) begin
                r_rdata <= m_rdata;
                r_ok    <= 1'b1;
            end else if (w_abort) begin
                r_ok    <= 1'b0;
            end
        end
    end

    // Grants are decoded from registered state, so they fall as RELEASE
    // begins and the reset state drives every output low.
    assign w_owned = (r_state == S_ISSUE) || (r_state == S_XFER);
    assign gnt0    = w_owned && !r_owner;
    assign gnt1    = w_owned &&  r_owner;
    assign done0   = (r_state == S_RELEASE) &&  r_ok && !r_owner;
    assign done1   = (r_state == S_RELEASE) &&  r_ok &&  r_owner;
    assign err0    = (r_state == S_RELEASE) && !r_ok && !r_owner;
    assign err1    = (r_state == S_RELEASE) && !r_ok &&  r_owner;
    assign m_start = w_start;
    assign m_wdata = r_m_wdata;
    assign rdata   = r_rdata;

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: width of one SPI master byte, for both transmit and receive.
REQ-002 Parameter TIMEOUT, default 100: maximum cycles spent in ISSUE+XFER before abort.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1  requester n wants one SPI transfer; held until done/err.
REQ-006 wdata0, wdata1  input  DATA_W  byte to send for requester n; sampled at grant.
REQ-007 gnt0, gnt1  output  1  requester n owns the SPI master.
REQ-008 done0, done1  output  1  1-cycle pulse: transfer for requester n completed; rdata valid.
REQ-009 err0, err1  output  1  1-cycle pulse: transfer for requester n aborted by timeout.
REQ-010 rdata  output  DATA_W  last received byte, shared by both requesters.
REQ-011 m_start  output  1  1-cycle start pulse to the SPI master.
REQ-012 m_wdata  output  DATA_W  byte presented to the SPI master, stable from m_start until RELEASE.
REQ-013 m_busy  input  1  SPI master is shifting and cannot accept a start.
REQ-014 m_done  input  1  1-cycle pulse: SPI master finished; m_rdata is valid in the same cycle.
REQ-015 m_rdata  input  DATA_W  byte received by the SPI master.

Function
REQ-016 FSM states: IDLE, ISSUE, XFER, RELEASE; the state register SHALL be encoded one-hot or binary (either is acceptable).
REQ-017 IDLE: if any req is high, select the winner, latch the winner's wdata into m_wdata, assert the winner's gnt, and go to ISSUE next cycle.
REQ-018 Arbitration: round-robin via a last-served pointer; if only one req is high, that requester wins; if both are high, the requester not last served wins.
REQ-019 Grant latency: a req first seen high in IDLE at edge N SHALL give gnt high after edge N, i.e. during cycle N+1.
REQ-020 ISSUE, m_busy low: assert m_start for exactly one cycle and go to XFER.
REQ-021 ISSUE, m_busy high: hold m_start low and stay in ISSUE.
REQ-022 XFER: on m_done, capture m_rdata into rdata and go to RELEASE with a completion flag set.
REQ-023 m_done seen in any state other than XFER SHALL be ignored; rdata is not updated.
REQ-024 Timeout counter: cleared on entry to ISSUE and incremented each cycle in ISSUE or XFER.
REQ-025 Timeout: when the counter reaches TIMEOUT-1 without m_done, go to RELEASE with an abort flag set; rdata is unchanged.
REQ-026 If m_done coincides with the timeout cycle, m_done wins: completion, no err.
REQ-027 RELEASE: deassert both gnt; pulse done (on completion) or err (on abort) for the served requester only, for one cycle.
REQ-028 RELEASE: update the last-served pointer to the served requester and return to IDLE.
REQ-029 Gap: at least one IDLE cycle separates consecutive grants, so a new gnt is earliest 2 cycles after the done/err pulse.
REQ-030 gnt0 and gnt1 SHALL never be high simultaneously; at most one of the done/err pulses is high in any cycle.
REQ-031 A req dropped while granted SHALL NOT abort the transfer; the FSM completes it normally and still pulses done/err.
REQ-032 wdata changes after grant SHALL NOT affect m_wdata.

Reset
REQ-033 While rst is low, the block SHALL be held with: state=IDLE, all gnt/done/err/m_start=0, m_wdata=0, rdata=0, timeout counter=0, last-served=1 (so requester 0 wins the first tie).
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no done/err pulse.
REQ-035 After rst deasserts, the first grant SHALL occur no earlier than the first posedge with rst high.

Verification
REQ-036 Single request: req0=1, wdata0=8'hA5, m_busy=0, m_done 5 cycles after m_start with m_rdata=8'h3C -> gnt0 next cycle, m_start 1 cycle with m_wdata=A5, done0 pulse, rdata=3C, gnt0 low.
REQ-037 Tie after reset: req0=req1=1 -> gnt0 first; then gnt1 after one IDLE gap.
REQ-038 Tie again: req0=req1=1 held -> grants alternate 0,1,0,1 over 4 transfers; gnt never overlaps.
REQ-039 Busy stall: m_busy=1 for 10 cycles after grant -> no m_start until m_busy=0, then exactly one m_start pulse.
REQ-040 Timeout: TIMEOUT=100, m_done never arrives -> err1 pulse 100 cycles after ISSUE entry, rdata unchanged, no done1.
REQ-041 Timeout tie-break: m_done on the timeout cycle -> done pulse and no err.
REQ-042 Reset abort: rst low during XFER -> all outputs 0 immediately; after release, a pending req1 is granted normally.
